// File: rtl/radar_feature_pkg.sv
// Shared constants and FSM encoding for the radar feature serializer.
package radar_feature_pkg;

  localparam int RANGE_WIDTH    = 128;
  localparam int VELOCITY_WIDTH = 64;
  localparam int ANGLE_WIDTH    = 64;
  localparam int FEATURE_WIDTH  = RANGE_WIDTH + VELOCITY_WIDTH + ANGLE_WIDTH;
  localparam int OUT_WIDTH      = 64;
  localparam int BEATS          = FEATURE_WIDTH / OUT_WIDTH;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

endpackage

// File: rtl/feature_fifo.sv
// Synchronous first-word-fall-through FIFO holding whole feature vectors.
module feature_fifo #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_wr, do_rd;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_wr);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_rd);
    level_d  = level_q;
    unique case ({do_wr, do_rd})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is not reset; the empty pointers guarantee stale words are never read.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/radar_feature_serializer.sv
// Buffers radar feature vectors and streams them MSB-slice first as valid/ready beats,
// counting vectors dropped while the FIFO is full.
module radar_feature_serializer #(
  parameter int FEATURE_WIDTH = radar_feature_pkg::FEATURE_WIDTH,
  parameter int OUT_WIDTH     = radar_feature_pkg::OUT_WIDTH,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in,
  input  logic [FEATURE_WIDTH-1:0]      feature_vector,
  output logic [OUT_WIDTH-1:0]          out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic [CNT_WIDTH-1:0]          drop_count,
  input  logic                          clear_stats
);

  import radar_feature_pkg::*;

  localparam int N_BEATS = FEATURE_WIDTH / OUT_WIDTH;
  localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(N_BEATS - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  if (FEATURE_WIDTH % OUT_WIDTH != 0) begin : g_bad_width
    $fatal(1, "FEATURE_WIDTH must be a multiple of OUT_WIDTH");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "FIFO_DEPTH must be a power of 2 and at least 2");
  end

  state_e                   state_q, state_d;
  logic [FEATURE_WIDTH-1:0] shift_q, shift_d;
  logic [BEAT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic                     overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0]     drop_cnt_q, drop_cnt_d;

  logic [FEATURE_WIDTH-1:0] fifo_rd_data;
  logic                     fifo_full, fifo_empty;
  logic                     pop, push, drop;

  feature_fifo #(
    .WIDTH (FEATURE_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (feature_vector),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    beat_cnt_d = beat_cnt_q;
    pop        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = fifo_rd_data;
          beat_cnt_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (beat_cnt_q == LAST_BEAT) begin
            // Reload straight from the FIFO head so vectors go out back to back.
            if (!fifo_empty) begin
              pop        = 1'b1;
              shift_d    = fifo_rd_data;
              beat_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shift_d    = shift_q << OUT_WIDTH;
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign push = valid_in && (!fifo_full || pop);
  assign drop = valid_in && fifo_full && !pop;

  // A drop in the clearing cycle survives the clear.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clear_stats) begin
      overflow_d = drop;
      drop_cnt_d = drop ? CNT_WIDTH'(1) : '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != CNT_MAX) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      beat_cnt_q <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      beat_cnt_q <= beat_cnt_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_valid  = (state_q == SEND);
  assign out_last   = (state_q == SEND) && (beat_cnt_q == LAST_BEAT);
  assign out_data   = shift_q[FEATURE_WIDTH-1 -: OUT_WIDTH];
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

endmodule

// File: tb/tb_radar_feature_serializer.sv
// Directed plus randomized bench for radar_feature_serializer against a queue-based
// transaction model; a narrow drop counter lets saturation be reached quickly.
module tb_radar_feature_serializer;

  localparam int FW    = 256;
  localparam int OW    = 64;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int BEATS = FW / OW;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic [FW-1:0] feature_vector;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic [CW-1:0] drop_count;
  logic          clear_stats;

  always #5 clk = ~clk;

  radar_feature_serializer #(
    .FEATURE_WIDTH (FW),
    .OUT_WIDTH     (OW),
    .FIFO_DEPTH    (DEPTH),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .valid_in       (valid_in),
    .feature_vector (feature_vector),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .drop_count     (drop_count),
    .clear_stats    (clear_stats)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int peak_level;

  // Transaction model: stored vectors, the vector on the wire and its beat index.
  logic [FW-1:0] mq[$];
  logic [FW-1:0] m_cur;
  int            m_beat;
  bit            m_sending;
  bit            m_ovf;
  int            m_cnt;

  // Handshakes observed on the DUT interface.
  logic [OW-1:0] hs_data[$];
  bit            hs_last[$];
  int            hs_cyc[$];

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] slice(input logic [FW-1:0] v, input int b);
    return v[(BEATS-1-b)*OW +: OW];
  endfunction

  function automatic logic [FW-1:0] rand_vec();
    logic [FW-1:0] v;
    for (int i = 0; i < FW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cur     = '0;
    m_sending = 0;
    m_beat    = 0;
    m_ovf     = 0;
    m_cnt     = 0;
  endtask

  task automatic model_edge(input bit vin, input logic [FW-1:0] fv, input bit rdy, input bit clr);
    bit pop;
    bit drop;
    pop = 0;
    if (!m_sending) begin
      if (mq.size() > 0) pop = 1;
    end else if (rdy) begin
      if (m_beat == BEATS-1) begin
        if (mq.size() > 0) pop = 1;
        else m_sending = 0;
      end else begin
        m_beat++;
      end
    end
    drop = vin && (mq.size() == DEPTH) && !pop;
    if (pop) begin
      m_cur     = mq.pop_front();
      m_beat    = 0;
      m_sending = 1;
    end
    if (vin && !drop) mq.push_back(fv);
    if (clr) begin
      m_ovf = drop;
      m_cnt = drop ? 1 : 0;
    end else if (drop) begin
      m_ovf = 1;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end
  endtask

  task automatic check_all();
    chk("out_valid", out_valid, m_sending);
    chk("out_last", out_last, m_sending && (m_beat == BEATS-1));
    if (m_sending) chk("out_data", out_data, slice(m_cur, m_beat));
    chk("fifo_level", fifo_level, mq.size());
    chk("overflow", overflow, m_ovf);
    chk("drop_count", drop_count, m_cnt);
  endtask

  task automatic hs_clear();
    hs_data.delete();
    hs_last.delete();
    hs_cyc.delete();
  endtask

  // One clock: drive, log any handshake, clock, update the model, sample 1 ns later.
  task automatic cycle(input bit vin, input logic [FW-1:0] fv, input bit rdy, input bit clr);
    valid_in       = vin;
    feature_vector = fv;
    out_ready      = rdy;
    clear_stats    = clr;
    if (out_valid && out_ready) begin
      hs_data.push_back(out_data);
      hs_last.push_back(out_last);
      hs_cyc.push_back(cyc);
    end
    @(posedge clk);
    model_edge(vin, fv, rdy, clr);
    cyc++;
    #1;
    check_all();
    if (int'(fifo_level) > peak_level) peak_level = int'(fifo_level);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, rdy, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_out_data"}, out_data, '0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_last"}, out_last, 1'b0);
    chk({tag, "_fifo_level"}, fifo_level, '0);
    chk({tag, "_overflow"}, overflow, 1'b0);
    chk({tag, "_drop_count"}, drop_count, '0);
  endtask

  logic [FW-1:0] v1;
  logic [FW-1:0] bv[5];
  logic [FW-1:0] ov[7];
  int            c0;
  bit            pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    reset          = 1'b1;
    valid_in       = 1'b0;
    feature_vector = '0;
    out_ready      = 1'b0;
    clear_stats    = 1'b0;
    peak_level     = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b0;

    // Single vector with fixed slices.
    v1 = {{16{4'h1}}, {16{4'h2}}, {16{4'h3}}, {16{4'h4}}};
    hs_clear();
    c0 = cyc;
    cycle(1'b1, v1, 1'b1, 1'b0);
    idle(7, 1'b1);
    chk("single_hs_count", hs_data.size(), 4);
    if (hs_data.size() == 4) begin
      chk("single_latency", hs_cyc[0] - c0, 2);
      chk("single_gapless", hs_cyc[3] - hs_cyc[0], 3);
      chk("single_beat0", hs_data[0], {16{4'h1}});
      chk("single_beat3", hs_data[3], {16{4'h4}});
      for (int b = 0; b < 4; b++) chk("single_last", hs_last[b], b == 3);
    end

    // Back-pressure with ready pattern 1,0,0,1.
    hs_clear();
    cycle(1'b1, v1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, pat[i % 4], 1'b0);
    chk("bp_hs_count", hs_data.size(), 4);
    for (int b = 0; b < hs_data.size() && b < 4; b++) chk("bp_beat", hs_data[b], slice(v1, b));

    // Burst of five vectors, sink always ready.
    hs_clear();
    peak_level = 0;
    for (int i = 0; i < 5; i++) bv[i] = rand_vec();
    for (int i = 0; i < 5; i++) cycle(1'b1, bv[i], 1'b1, 1'b0);
    idle(24, 1'b1);
    chk("burst_hs_count", hs_data.size(), 20);
    if (hs_data.size() == 20) begin
      chk("burst_gapless", hs_cyc[19] - hs_cyc[0], 19);
      for (int k = 0; k < 20; k++) chk("burst_beat", hs_data[k], slice(bv[k/4], k%4));
    end
    chk("burst_peak_level", peak_level, 4);
    chk("burst_overflow", overflow, 1'b0);

    // Overflow: seven vectors into a stalled sink, then clear versus drop.
    hs_clear();
    for (int i = 0; i < 7; i++) ov[i] = rand_vec();
    for (int i = 0; i < 7; i++) cycle(1'b1, ov[i], 1'b0, 1'b0);
    chk("ovf_drop_count", drop_count, 2);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_level_full", fifo_level, 4);
    cycle(1'b1, rand_vec(), 1'b0, 1'b1);
    chk("clr_drop_flag", overflow, 1'b1);
    chk("clr_drop_count", drop_count, 1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    chk("clr_only_flag", overflow, 1'b0);
    chk("clr_only_count", drop_count, 0);
    idle(30, 1'b1);
    chk("ovf_hs_count", hs_data.size(), 20);
    for (int k = 0; k < hs_data.size() && k < 20; k++) chk("ovf_beat", hs_data[k], slice(ov[k/4], k%4));

    // Drop counter saturation.
    for (int i = 0; i < 24; i++) cycle(1'b1, rand_vec(), 1'b0, 1'b0);
    chk("sat_drop_count", drop_count, (1 << CW) - 1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    idle(30, 1'b1);

    // Reset after beat 1 with two vectors queued.
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_vec(), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    chk("pre_reset_level", fifo_level, 2);
    chk("pre_reset_valid", out_valid, 1'b1);
    valid_in = 1'b0;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_reset_values("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    hs_clear();
    idle(10, 1'b1);
    chk("post_reset_hs", hs_data.size(), 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 99) < 45, rand_vec(), $urandom_range(0, 99) < 70,
            $urandom_range(0, 99) < 3);
    idle(40, 1'b1);
    chk("final_drain_valid", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
